// File: rtl/fb_draw_pkg.sv
// fb_draw_pkg
// Shared types and helpers for the framebuffer draw scheduler.
//   state_t  : scheduler mode (DRAW arbitration / CLEAR sweep)
//   CLIP_W   : width of the saturating dropped-request counter
//   in_range : true when (x, y) lies inside the visible area
package fb_draw_pkg;

    typedef enum logic {
        DRAW  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int unsigned CLIP_W = 16;

    function automatic logic in_range(input int unsigned x,
                                      input int unsigned y,
                                      input int unsigned h_pixels,
                                      input int unsigned v_pixels);
        return (x < h_pixels) && (y < v_pixels);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin grant logic. The pointer register lives in
// the parent; this block only picks the winner and the follow-on pointer.
//   valid    in  N   request vector
//   ptr      in  PW  highest-priority channel this cycle
//   grant    out N   one-hot grant (all zero when nothing is valid)
//   next_ptr out PW  channel after the winner, or ptr when no grant
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan from ptr upward with wrap-around; first valid channel wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PW'((32'(ptr) + off) % N);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = PW'((32'(idx) + 1) % N);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_draw_scheduler.sv
// fb_draw_scheduler
// Front end for the VGA framebuffer write port: round-robin arbitration of
// N_CH drawing channels onto one registered pixel-write port, a full-screen
// clear sweep, and the slow tick that paces the drawing state machines.
//   CLOCK_50     in   system clock (rising edge)
//   reset        in   synchronous, active-high
//   clear_req    in   start a clear sweep (ignored while sweeping)
//   clear_color  in   sweep colour, sampled on the clear-start cycle
//   req_valid    in   per-channel pixel request
//   req_x/y/color in  per-channel packed coordinates and colour
//   req_ready    out  one-hot combinational grant
//   fb_x/y/color out  registered write address and colour
//   fb_write     out  registered write strobe
//   busy_clear   out  high while sweep pixels are issued
//   tick         out  one-cycle pulse every TICK_DIV cycles
//   clip_cnt     out  saturating count of dropped out-of-range requests
module fb_draw_scheduler
    import fb_draw_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned XW       = 11,
    parameter int unsigned YW       = 11,
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_PIXELS = 480,
    parameter int unsigned COLOR_W  = 1,
    parameter int unsigned TICK_DIV = 262144
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      clear_req,
    input  logic [COLOR_W-1:0]        clear_color,
    input  logic [N_CH-1:0]           req_valid,
    input  logic [N_CH*XW-1:0]        req_x,
    input  logic [N_CH*YW-1:0]        req_y,
    input  logic [N_CH*COLOR_W-1:0]   req_color,
    output logic [N_CH-1:0]           req_ready,
    output logic [XW-1:0]             fb_x,
    output logic [YW-1:0]             fb_y,
    output logic [COLOR_W-1:0]        fb_color,
    output logic                      fb_write,
    output logic                      busy_clear,
    output logic                      tick,
    output logic [CLIP_W-1:0]         clip_cnt
);

    localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TW = $clog2(TICK_DIV);

    localparam logic [XW-1:0] X_LAST    = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_PIXELS - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       next_ptr;
    logic [N_CH-1:0]     grant;
    logic                accept;
    logic [XW-1:0]       sel_x;
    logic [YW-1:0]       sel_y;
    logic [COLOR_W-1:0]  sel_color;
    logic [TW-1:0]       tick_cnt;

    rr_arbiter #(
        .N  (N_CH),
        .PW (PW)
    ) u_arb (
        .valid    (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // A clear request pre-empts any grant in the same cycle.
    assign req_ready = (state == DRAW && !clear_req) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            if (req_ready[ch]) begin
                sel_x     = req_x[ch*XW +: XW];
                sel_y     = req_y[ch*YW +: YW];
                sel_color = req_color[ch*COLOR_W +: COLOR_W];
            end
        end
    end

    // The sweep reuses fb_x/fb_y as its position counters and fb_color as
    // the latched clear colour, since nothing else drives them mid-sweep.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= DRAW;
            ptr        <= '0;
            fb_x       <= '0;
            fb_y       <= '0;
            fb_color   <= '0;
            fb_write   <= 1'b0;
            busy_clear <= 1'b0;
            tick       <= 1'b0;
            tick_cnt   <= '0;
            clip_cnt   <= '0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            tick     <= (tick_cnt == TICK_LAST);
            fb_write <= 1'b0;

            case (state)
                DRAW: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        busy_clear <= 1'b1;
                        fb_x       <= '0;
                        fb_y       <= '0;
                        fb_color   <= clear_color;
                        fb_write   <= 1'b1;
                    end else if (accept) begin
                        ptr <= next_ptr;
                        if (in_range(32'(sel_x), 32'(sel_y), H_PIXELS, V_PIXELS)) begin
                            fb_x     <= sel_x;
                            fb_y     <= sel_y;
                            fb_color <= sel_color;
                            fb_write <= 1'b1;
                        end else if (clip_cnt != '1) begin
                            clip_cnt <= clip_cnt + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    // Last pixel is on the port this cycle: leave the sweep.
                    if (fb_x == X_LAST && fb_y == Y_LAST) begin
                        state      <= DRAW;
                        busy_clear <= 1'b0;
                    end else begin
                        fb_write <= 1'b1;
                        if (fb_x == X_LAST) begin
                            fb_x <= '0;
                            fb_y <= fb_y + 1'b1;
                        end else begin
                            fb_x <= fb_x + 1'b1;
                        end
                    end
                end
                default: state <= DRAW;
            endcase
        end
    end

endmodule

// File: doc/fb_draw_scheduler.md
# fb_draw_scheduler

Parametrised front end for the VGA framebuffer write port. It arbitrates N drawing channels (line drawers, sprite/pipe drawers) round-robin onto a single registered pixel-write port. It runs a full-screen clear sweep on request and generates the slow clock-enable tick that paces the drawing state machines. It sits between the drawing clients and `VGA_framebuffer`, replacing the hard-wired switch mux and free-running divider.

## Interface
Parameters:
- N_CH, 2, number of drawing channels (≥1)
- XW, 11, x coordinate width
- YW, 11, y coordinate width
- H_PIXELS, 640, visible width; valid x is 0..H_PIXELS-1
- V_PIXELS, 480, visible height; valid y is 0..V_PIXELS-1
- COLOR_W, 1, pixel colour width
- TICK_DIV, 262144, tick period in CLOCK_50 cycles (≥2)

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- clear_req  in  1  single-cycle or level request to start a clear sweep
- clear_color  in  COLOR_W  colour written by the sweep; sampled on the clear-start cycle
- req_valid  in  N_CH  per-channel pixel request
- req_x  in  N_CH×XW  per-channel x
- req_y  in  N_CH×YW  per-channel y
- req_color  in  N_CH×COLOR_W  per-channel colour
- req_ready  out  N_CH  one-hot grant; a transfer occurs when valid&ready
- fb_x  out  XW  registered write x
- fb_y  out  YW  registered write y
- fb_color  out  COLOR_W  registered write colour
- fb_write  out  1  registered write strobe
- busy_clear  out  1  high while sweep pixels are being issued
- tick  out  1  one-cycle pulse every TICK_DIV cycles
- clip_cnt  out  16  saturating count of dropped out-of-range requests

## Operation
- Reset values: fb_x=0, fb_y=0, fb_color=0, fb_write=0, busy_clear=0, tick=0, clip_cnt=0, req_ready=0. Round-robin pointer=0, state=DRAW, tick counter=0.
- FSM states:
  - DRAW: arbitration active.
  - CLEAR: sweep active.
  - DRAW→CLEAR when clear_req=1.
  - CLEAR→DRAW after pixel (H_PIXELS-1, V_PIXELS-1) is issued.
- DRAW:
  - req_ready is combinational: the lowest-index valid channel at or above the pointer, with wrap-around; otherwise 0.
  - After a grant to channel i, the pointer becomes (i+1) mod N_CH. With no valid requests the pointer holds.
  - If clear_req=1 in DRAW, req_ready=0 that cycle; clear wins.
- Accept:
  - In-range request: fb_x/fb_y/fb_color load the request and fb_write=1 next cycle.
  - Out-of-range request (x≥H_PIXELS or y≥V_PIXELS): still accepted (ready high), fb_write=0, clip_cnt increments, saturating at 0xFFFF.
- Non-accept cycles: fb_write=0 next cycle. fb_x/fb_y/fb_color hold.
- CLEAR sweep:
  - One pixel per cycle; x increments fastest, y on x wrap.
  - Issues (0,0)…(H_PIXELS-1,V_PIXELS-1) with fb_write=1 and fb_color = latched clear_color.
  - req_ready=0 throughout. clear_req during CLEAR is ignored.
- Tick counter runs 0..TICK_DIV-1, wraps, and is independent of FSM state. tick=1 on the cycle after the counter equals TICK_DIV-1.
- Reset mid-sweep or mid-transfer: abort immediately and return to reset values. No partial state is retained.

## Timing
- Accept at cycle t → fb_* valid with fb_write=1 at t+1. Throughput is 1 pixel/cycle.
- clear_req at t (state DRAW):
  - busy_clear=1 and first sweep pixel on fb_* at t+1.
  - Last pixel at t+H_PIXELS·V_PIXELS.
  - busy_clear=0 and req_ready available from t+H_PIXELS·V_PIXELS+1.
- tick period is exactly TICK_DIV cycles. First tick occurs TICK_DIV cycles after reset deasserts.
- Clients must hold req_* stable while valid&!ready. The block does not require this for correctness, but samples only on accept.

## Structure
- Package fb_draw_pkg holds:
  - the state enum (DRAW, CLEAR);
  - the clip counter width (16);
  - a helper function in_range(x,y).
- Sub-module rr_arbiter (parameter N): inputs valid and pointer; outputs a one-hot grant and next pointer. Purely combinational, with the pointer register kept in the parent.
- Tick divider, sweep counters and output registers live in fb_draw_scheduler.

## Test plan
Bench parameters: N_CH=3, H_PIXELS=4, V_PIXELS=3, TICK_DIV=4.
- Reset, then idle 12 cycles → tick pulses at cycles 4, 8, 12 after reset release; fb_write stays 0.
- All three channels hold valid with distinct coordinates for 6 cycles → grants 0,1,2,0,1,2; each fb_* matches the granted request one cycle later.
- clear_req pulse with clear_color=1 → 12 consecutive writes (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2), all colour 1. busy_clear high exactly 12 cycles; req_ready=0 throughout.
- clear_req in the same cycle as req_valid=3'b010 → no grant that cycle; channel 1 is granted on the cycle after busy_clear falls.
- Channel 0 requests (4,0) and then (0,3) → both accepted, fb_write=0 for both, clip_cnt=2.
- Assert reset at sweep pixel 5 → next cycle all outputs are at reset values; a new clear_req restarts the sweep at (0,0).
